// File: rtl/arb2_dec_ctrl.sv
// Two-requester round-robin arbiter driving a one-hot 1-to-2 decoder select.
// Optional hold-time preemption is enabled by defining ARB2_PREEMPT_EN.
module arb2_dec_ctrl #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       sel,
  output logic       busy,
  output logic       preempt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] gnt_nxt;
  logic       sel_nxt;
  logic       busy_nxt;

  generate
    if (HOLD_MAX < 1 || HOLD_MAX > 15) begin : g_hold_range
      $error("arb2_dec_ctrl: HOLD_MAX must be in 1..15");
    end
  endgenerate

`ifdef ARB2_PREEMPT_EN
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(15);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             preempt_nxt;
`endif

  // Next-state and registered-output decode
  always_comb begin
    state_nxt = state;
`ifdef ARB2_PREEMPT_EN
    cnt_nxt     = '0;
    preempt_nxt = 1'b0;
`endif
    case (state)
      IDLE: begin
        case (req)
          2'b01:   state_nxt = GNT0;
          2'b10:   state_nxt = GNT1;
          2'b11:   state_nxt = sel ? GNT0 : GNT1;
          default: state_nxt = IDLE;
        endcase
      end
      GNT0: begin
        if (!req[0]) begin
          state_nxt = IDLE;
`ifdef ARB2_PREEMPT_EN
        end else if (cnt == HOLD_LAST && req[1]) begin
          state_nxt   = IDLE;
          preempt_nxt = 1'b1;
        end else begin
          cnt_nxt = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);
`endif
        end
      end
      GNT1: begin
        if (!req[1]) begin
          state_nxt = IDLE;
`ifdef ARB2_PREEMPT_EN
        end else if (cnt == HOLD_LAST && req[0]) begin
          state_nxt   = IDLE;
          preempt_nxt = 1'b1;
        end else begin
          cnt_nxt = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase

    gnt_nxt  = {state_nxt == GNT1, state_nxt == GNT0};
    busy_nxt = |gnt_nxt;
    case (state_nxt)
      GNT0:    sel_nxt = 1'b0;
      GNT1:    sel_nxt = 1'b1;
      default: sel_nxt = sel;
    endcase
  end

  // State and output registers; the decoded grant updates on the sampling edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= 2'b00;
      sel   <= 1'b0;
      busy  <= 1'b0;
`ifdef ARB2_PREEMPT_EN
      cnt     <= '0;
      preempt <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      sel   <= sel_nxt;
      busy  <= busy_nxt;
`ifdef ARB2_PREEMPT_EN
      cnt     <= cnt_nxt;
      preempt <= preempt_nxt;
`endif
    end
  end

`ifndef ARB2_PREEMPT_EN
  assign preempt = 1'b0;
`endif

endmodule

// File: tb/tb_arb2_dec_ctrl.sv
// Directed self-checking bench for arb2_dec_ctrl (default and ARB2_PREEMPT_EN builds).
module tb_arb2_dec_ctrl;

`ifdef ARB2_PREEMPT_EN
  localparam int unsigned HOLD = 4;
`else
  localparam int unsigned HOLD = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [1:0] gnt;
  logic       sel;
  logic       busy;
  logic       preempt;

  int checks   = 0;
  int failures = 0;

  arb2_dec_ctrl #(.HOLD_MAX(HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .preempt (preempt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] eg, input logic es,
                         input logic eb, input logic ep);
    chk({tag, ".gnt"}, gnt, eg);
    chk({tag, ".sel"}, {1'b0, sel}, {1'b0, es});
    chk({tag, ".busy"}, {1'b0, busy}, {1'b0, eb});
    chk({tag, ".preempt"}, {1'b0, preempt}, {1'b0, ep});
  endtask

  task automatic step(input logic [1:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 2'b00;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req   = 2'b00;
    #3;
    chk_all("reset", 2'b00, 1'b0, 1'b0, 1'b0);
    do_reset();

    // single requester 0: three cycles of grant, then release
    step(2'b01); chk_all("r0_c1", 2'b01, 1'b0, 1'b1, 1'b0);
    step(2'b01); chk_all("r0_c2", 2'b01, 1'b0, 1'b1, 1'b0);
    step(2'b01); chk_all("r0_c3", 2'b01, 1'b0, 1'b1, 1'b0);
    step(2'b00); chk_all("r0_rel", 2'b00, 1'b0, 1'b0, 1'b0);
    step(2'b00); chk_all("r0_idle", 2'b00, 1'b0, 1'b0, 1'b0);

    // both request after reset: requester 1 first, break-before-make handover
    do_reset();
    step(2'b11); chk_all("both_g1a", 2'b10, 1'b1, 1'b1, 1'b0);
    step(2'b11); chk_all("both_g1b", 2'b10, 1'b1, 1'b1, 1'b0);
    step(2'b01); chk_all("both_gap", 2'b00, 1'b1, 1'b0, 1'b0);
    step(2'b01); chk_all("both_g0", 2'b01, 1'b0, 1'b1, 1'b0);
    step(2'b00); chk_all("both_end", 2'b00, 1'b0, 1'b0, 1'b0);

    // requester 0 drops for one cycle while requester 1 waits
    step(2'b01); chk_all("tog_g0", 2'b01, 1'b0, 1'b1, 1'b0);
    step(2'b11); chk_all("tog_ign", 2'b01, 1'b0, 1'b1, 1'b0);
    step(2'b10); chk_all("tog_gap", 2'b00, 1'b0, 1'b0, 1'b0);
    step(2'b11); chk_all("tog_g1a", 2'b10, 1'b1, 1'b1, 1'b0);
    step(2'b11); chk_all("tog_g1b", 2'b10, 1'b1, 1'b1, 1'b0);
    step(2'b01); chk_all("tog_gap2", 2'b00, 1'b1, 1'b0, 1'b0);
    step(2'b01); chk_all("tog_g0b", 2'b01, 1'b0, 1'b1, 1'b0);
    step(2'b00); chk_all("tog_end", 2'b00, 1'b0, 1'b0, 1'b0);

    do_reset();
`ifdef ARB2_PREEMPT_EN
    // constant contention with HOLD_MAX=4: 4x10, 00+preempt, 4x01, 00+preempt, 10
    for (int i = 0; i < 4; i++) begin
      step(2'b11); chk_all("pre_g1", 2'b10, 1'b1, 1'b1, 1'b0);
    end
    step(2'b11); chk_all("pre_cut1", 2'b00, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(2'b11); chk_all("pre_g0", 2'b01, 1'b0, 1'b1, 1'b0);
    end
    step(2'b11); chk_all("pre_cut0", 2'b00, 1'b0, 1'b0, 1'b1);
    step(2'b11); chk_all("pre_g1again", 2'b10, 1'b1, 1'b1, 1'b0);
    step(2'b10); chk_all("pre_solo", 2'b10, 1'b1, 1'b1, 1'b0);
`else
    // constant contention without preemption: requester 1 keeps the grant
    for (int i = 0; i < 40; i++) begin
      step(2'b11); chk_all("hold", 2'b10, 1'b1, 1'b1, 1'b0);
    end
`endif

    // asynchronous reset in the middle of a requester-1 grant
    do_reset();
    step(2'b11); chk_all("ar_g1", 2'b10, 1'b1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_all("ar_async", 2'b00, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 chk_all("ar_held", 2'b00, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    step(2'b11); chk_all("ar_regnt", 2'b10, 1'b1, 1'b1, 1'b0);
    step(2'b00); chk_all("ar_end", 2'b00, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arb2_dec_ctrl.md
ARB2_DEC_CTRL -- requirements
Module: arb2_dec_ctrl

Interface
REQ-001 The block SHALL have parameter HOLD_MAX, default 8, meaning the maximum consecutive grant cycles before preemption (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port req, input, 2 bits: request from requester 0 (bit 0) and requester 1 (bit 1), level-sensitive.
REQ-005 The block SHALL have port gnt, output, 2 bits: one-hot grant, i.e. the decoded select of the shared resource; 2'b00 means no owner.
REQ-006 The block SHALL have port sel, output, 1 bit: index of the current owner, or of the last owner when idle (select input of the 1-to-2 decoder).
REQ-007 The block SHALL have port busy, output, 1 bit: high whenever gnt is nonzero.
REQ-008 The block SHALL have port preempt, output, 1 bit: one-cycle pulse when a grant is forcibly revoked.

Function
REQ-009 The block SHALL implement an FSM with states IDLE, GNT0 and GNT1, with all outputs registered.
REQ-010 gnt SHALL be 2'b01 only in GNT0, 2'b10 only in GNT1, and 2'b00 in IDLE; gnt SHALL never be 2'b11.
REQ-011 In IDLE with req=01, the FSM SHALL go to GNT0; with req=10, to GNT1; with req=11, to the requester other than sel (round-robin); with req=00, it SHALL stay in IDLE.
REQ-012 Grant latency SHALL be exactly 1 cycle: a req sampled in IDLE at edge N SHALL produce gnt at edge N.
REQ-013 In GNTx, while req[x]=1 and no preemption occurs, the FSM SHALL stay in GNTx.
REQ-014 In GNTx, when req[x]=0 is sampled, the FSM SHALL return to IDLE, giving at least one gnt=00 cycle between owners (break-before-make).
REQ-015 sel SHALL update on entry to GNTx to value x, and SHALL hold that value through IDLE.
REQ-016 The block SHALL maintain a 4-bit hold counter that clears on entry to GNTx, increments each cycle in GNTx, and saturates at 15.
REQ-017 A requester that drops and re-raises req while the other requester is requesting SHALL be served only after the other requester (fairness through sel).
REQ-018 Changes on req[x] while in GNTy (y≠x) SHALL NOT affect gnt until the FSM returns to IDLE.

Reset
REQ-019 When rst_n=0, the block SHALL immediately, independent of clk, force state=IDLE, gnt=00, sel=0, busy=0, preempt=0 and hold counter=0.
REQ-020 Reset asserted mid-grant SHALL abort the grant with no preempt pulse.
REQ-021 After rst_n is released, the first request SHALL be arbitrated as if sel=0, so req=11 grants requester 1 first.

Configuration
REQ-022 The block SHALL define macro ARB2_PREEMPT_EN.
REQ-023 With ARB2_PREEMPT_EN defined: in GNTx, when the hold counter equals HOLD_MAX-1 and req[other]=1, the FSM SHALL go to IDLE on the next edge and preempt SHALL pulse high for exactly that one cycle; if req[other]=0, the grant SHALL continue.
REQ-024 With ARB2_PREEMPT_EN undefined: the hold counter and its logic SHALL be absent, preempt SHALL be tied 0, and a grant SHALL end only by req[x] deasserting or reset.

Verification
REQ-025 Reset, then req=01 for 3 cycles, then 00 -> gnt=01 one cycle after req, held 3 cycles, then 00; sel=0; busy tracks gnt.
REQ-026 After reset, req=11 held -> gnt=10 first; when req[1] drops, one gnt=00 cycle follows, then gnt=01; sel goes 1 -> 0.
REQ-027 Back-to-back toggling: requester 0 drops for 1 cycle while req[1]=1 -> requester 1 is served before requester 0 regains the grant.
REQ-028 ARB2_PREEMPT_EN, HOLD_MAX=4, req=11 constant -> grants alternate 4 cycles 10, 1 cycle 00 with preempt=1, 4 cycles 01, and so on.
REQ-029 ARB2_PREEMPT_EN undefined, req=11 constant for 40 cycles -> gnt stays 10 and preempt stays 0 throughout.
REQ-030 rst_n pulsed low asynchronously (between clk edges) during GNT1 -> gnt=00 and sel=0 immediately, preempt=0; after release, req=11 regrants 10 with 1-cycle latency.
